// File: rtl/bp_pkg.sv
// Branch-prediction types and defaults shared by level_2_predictor and branch_resolve_queue.
package bp_pkg;

  localparam int BP_PC_W  = 5;
  localparam int BP_DEPTH = 4;
  localparam int BP_CNT_W = 8;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
    logic [BP_PC_W-1:0] target;
  } pred_entry_t;

  // Fall-through PC; wraps modulo 2^BP_PC_W.
  function automatic logic [BP_PC_W-1:0] next_pc(input logic [BP_PC_W-1:0] pc);
    return pc + BP_PC_W'(1);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// Circular buffer of in-flight predictions with push, pop and whole-queue flush.
module pred_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [OCC_W-1:0] count_reg;
  logic [W-1:0]     mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == OCC_W'(DEPTH));
  assign empty = (count_reg == '0);

  // A flush wins over a same-cycle push: the pushed entry is wrong-path too.
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty;

  assign rd_data = mem[head_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [W-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (wr_en && tail_reg == PTR_W'(gi))
          slot_reg <= wr_data;
      end
      assign mem[gi] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wr_en)
        tail_reg <= tail_reg + PTR_W'(1);
      if (rd_en)
        head_reg <= head_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + OCC_W'(1);
        2'b01:   count_reg <= count_reg - OCC_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight branch predictions, checks them against execute's resolution,
// and produces redirect, predictor training updates and hit/miss statistics.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int PC_W  = BP_PC_W,
  parameter int DEPTH = BP_DEPTH,
  parameter int CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             res_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t          wr_entry;
  entry_t          head;
  logic            full;
  logic            empty;
  logic            resolve;
  logic            wrong;
  logic [PC_W-1:0] redirect_next;

  logic             mispredict_reg;
  logic [PC_W-1:0]  redirect_pc_reg;
  logic             upd_valid_reg;
  logic [PC_W-1:0]  upd_pc_reg;
  logic             upd_taken_reg;
  logic             res_err_reg;
  logic [CNT_W-1:0] hit_cnt_reg;
  logic [CNT_W-1:0] miss_cnt_reg;

  assign wr_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  pred_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (pred_valid),
    .pop     (resolve),
    .flush   (resolve && wrong),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign pred_ready = !full;
  assign resolve    = res_valid && !empty;

  // Target only matters when both sides agree the branch was taken.
  assign wrong = (res_taken != head.taken) ||
                 (res_taken && head.taken && (res_target != head.target));

  assign redirect_next = res_taken ? res_target : head.pc + PC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_reg  <= 1'b0;
      redirect_pc_reg <= '0;
      upd_valid_reg   <= 1'b0;
      upd_pc_reg      <= '0;
      upd_taken_reg   <= 1'b0;
      res_err_reg     <= 1'b0;
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
    end else begin
      mispredict_reg <= resolve && wrong;
      upd_valid_reg  <= resolve;
      if (res_valid && empty)
        res_err_reg <= 1'b1;
      if (resolve) begin
        upd_pc_reg    <= head.pc;
        upd_taken_reg <= res_taken;
        if (wrong) begin
          redirect_pc_reg <= redirect_next;
          if (miss_cnt_reg != '1)
            miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
        end else if (hit_cnt_reg != '1) begin
          hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign mispredict  = mispredict_reg;
  assign redirect_pc = redirect_pc_reg;
  assign upd_valid   = upd_valid_reg;
  assign upd_pc      = upd_pc_reg;
  assign upd_taken   = upd_taken_reg;
  assign res_err     = res_err_reg;
  assign hit_cnt     = hit_cnt_reg;
  assign miss_cnt    = miss_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (PC_W=5, DEPTH=4, CNT_W=8).
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pred_valid = 1'b0;
  logic       pred_ready;
  logic [4:0] pred_pc = '0;
  logic       pred_taken = 1'b0;
  logic [4:0] pred_target = '0;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic [4:0] res_target = '0;
  logic       mispredict;
  logic [4:0] redirect_pc;
  logic       upd_valid;
  logic [4:0] upd_pc;
  logic       upd_taken;
  logic       res_err;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.PC_W(5), .DEPTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .res_err     (res_err),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_one(input logic [4:0] pc, input logic t, input logic [4:0] tgt);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = t; pred_target = tgt;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve_one(input logic t, input logic [4:0] tgt);
    res_valid = 1'b1; res_taken = t; res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, res_err, hit_cnt, miss_cnt} !== '0 ||
        pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_init outputs=%h ready=%b required all-zero ready=1",
               {mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, res_err, hit_cnt, miss_cnt}, pred_ready);
    end
    do_reset();
    push_one(5'd3, 1'b0, 5'd0);
    push_one(5'd4, 1'b0, 5'd0);
    push_one(5'd5, 1'b0, 5'd0);
    resolve_one(1'b0, 5'd0);
    checks++;
    if (upd_valid !== 1'b1 || hit_cnt !== 8'd1) begin
      failures++;
      $display("FAIL reset_pre upd_valid=%b hit_cnt=%0d required 1 1", upd_valid, hit_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (upd_valid !== 1'b0 || hit_cnt !== 8'd0 || pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async upd_valid=%b hit_cnt=%0d ready=%b required 0 0 1", upd_valid, hit_cnt, pred_ready);
    end
    rst = 1'b0;
    tick();
    resolve_one(1'b0, 5'd0);
    checks++;
    if (res_err !== 1'b1 || upd_valid !== 1'b0 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL reset_res_err res_err=%b upd_valid=%b mispredict=%b required 1 0 0", res_err, upd_valid, mispredict);
    end
    $display("test_reset done");
  endtask

  task automatic test_correct_stream();
    logic [4:0] pat;
    logic t;
    pat = 5'b01101;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      t = pat[i % 5];
      push_one(5'b01100, t, 5'b01001);
      resolve_one(t, 5'b01001);
      checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 5'b01100 || upd_taken !== t || mispredict !== 1'b0) begin
        failures++;
        $display("FAIL stream_%0d upd_valid=%b upd_pc=%b upd_taken=%b mispredict=%b required 1 01100 %b 0",
                 i, upd_valid, upd_pc, upd_taken, mispredict, t);
      end
    end
    checks++;
    if (hit_cnt !== 8'd20 || miss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL stream_counts hit=%0d miss=%0d required 20 0", hit_cnt, miss_cnt);
    end
    $display("test_correct_stream done hit_cnt=%0d", hit_cnt);
  endtask

  task automatic test_mispredict();
    do_reset();
    push_one(5'b01100, 1'b0, 5'b00000);
    resolve_one(1'b1, 5'b01001);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 5'b01001 || miss_cnt !== 8'd1 ||
        upd_valid !== 1'b1 || upd_pc !== 5'b01100 || upd_taken !== 1'b1) begin
      failures++;
      $display("FAIL mispredict_taken mp=%b redirect=%b miss=%0d upd=%b/%b/%b required 1 01001 1 1/01100/1",
               mispredict, redirect_pc, miss_cnt, upd_valid, upd_pc, upd_taken);
    end
    resolve_one(1'b0, 5'd0);
    checks++;
    if (mispredict !== 1'b0 || upd_valid !== 1'b0 || res_err !== 1'b1) begin
      failures++;
      $display("FAIL mispredict_empty mp=%b upd_valid=%b res_err=%b required 0 0 1", mispredict, upd_valid, res_err);
    end
    $display("test_mispredict done");
  endtask

  task automatic test_redirect();
    do_reset();
    push_one(5'b01100, 1'b1, 5'b01001);
    resolve_one(1'b0, 5'b01001);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 5'b01101) begin
      failures++;
      $display("FAIL redirect_nt mp=%b redirect=%b required 1 01101", mispredict, redirect_pc);
    end
    push_one(5'b11111, 1'b1, 5'b00010);
    resolve_one(1'b0, 5'b00010);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 5'b00000 || upd_pc !== 5'b11111) begin
      failures++;
      $display("FAIL redirect_wrap mp=%b redirect=%b upd_pc=%b required 1 00000 11111", mispredict, redirect_pc, upd_pc);
    end
    push_one(5'b01100, 1'b1, 5'b01001);
    resolve_one(1'b1, 5'b00111);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 5'b00111 || miss_cnt !== 8'd3) begin
      failures++;
      $display("FAIL redirect_target mp=%b redirect=%b miss=%0d required 1 00111 3", mispredict, redirect_pc, miss_cnt);
    end
    push_one(5'b01100, 1'b0, 5'b01001);
    resolve_one(1'b0, 5'b00111);
    checks++;
    if (mispredict !== 1'b0 || hit_cnt !== 8'd1 || miss_cnt !== 8'd3) begin
      failures++;
      $display("FAIL nt_target_ignored mp=%b hit=%0d miss=%0d required 0 1 3", mispredict, hit_cnt, miss_cnt);
    end
    $display("test_redirect done");
  endtask

  task automatic test_full();
    logic [4:0] order [4];
    order[0] = 5'd3; order[1] = 5'd4; order[2] = 5'd7; order[3] = 5'd8;
    do_reset();
    for (int i = 1; i <= 4; i++) push_one(5'(i), 1'b0, 5'd0);
    checks++;
    if (pred_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready ready=%b required 0", pred_ready);
    end
    push_one(5'd5, 1'b0, 5'd0);
    // full: resolve pops pc 1, the concurrent push of pc 6 is refused
    pred_valid = 1'b1; pred_pc = 5'd6; pred_taken = 1'b0;
    resolve_one(1'b0, 5'd0);
    pred_valid = 1'b0;
    checks++;
    if (upd_pc !== 5'd1 || pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop upd_pc=%0d ready=%b required 1 1", upd_pc, pred_ready);
    end
    pred_valid = 1'b1; pred_pc = 5'd7; pred_taken = 1'b0;
    resolve_one(1'b0, 5'd0);
    pred_valid = 1'b0;
    checks++;
    if (upd_pc !== 5'd2 || pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_pop_same upd_pc=%0d ready=%b required 2 1", upd_pc, pred_ready);
    end
    push_one(5'd8, 1'b0, 5'd0);
    checks++;
    if (pred_ready !== 1'b0) begin
      failures++;
      $display("FAIL refill_ready ready=%b required 0", pred_ready);
    end
    for (int i = 0; i < 4; i++) begin
      resolve_one(1'b0, 5'd0);
      checks++;
      if (upd_valid !== 1'b1 || upd_pc !== order[i]) begin
        failures++;
        $display("FAIL order_%0d upd_valid=%b upd_pc=%0d required 1 %0d", i, upd_valid, upd_pc, order[i]);
      end
    end
    resolve_one(1'b0, 5'd0);
    checks++;
    if (upd_valid !== 1'b0 || res_err !== 1'b1 || hit_cnt !== 8'd6) begin
      failures++;
      $display("FAIL full_drain upd_valid=%b res_err=%b hit=%0d required 0 1 6", upd_valid, res_err, hit_cnt);
    end
    $display("test_full done");
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(5'(10 + i), 1'b1, 5'd20);
    pred_valid = 1'b1; pred_pc = 5'd30; pred_taken = 1'b1; pred_target = 5'd20;
    resolve_one(1'b0, 5'd0);
    pred_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 5'd11 || pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full mp=%b redirect=%0d ready=%b required 1 11 1", mispredict, redirect_pc, pred_ready);
    end
    resolve_one(1'b1, 5'd20);
    checks++;
    if (res_err !== 1'b1 || upd_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty res_err=%b upd_valid=%b required 1 0", res_err, upd_valid);
    end
    // not full, so the concurrent push is only stopped by the flush
    push_one(5'd1, 1'b1, 5'd20);
    push_one(5'd2, 1'b1, 5'd20);
    pred_valid = 1'b1; pred_pc = 5'd9; pred_taken = 1'b1; pred_target = 5'd20;
    resolve_one(1'b1, 5'd21);
    pred_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 5'd21 || miss_cnt !== 8'd2) begin
      failures++;
      $display("FAIL flush_partial mp=%b redirect=%0d miss=%0d required 1 21 2", mispredict, redirect_pc, miss_cnt);
    end
    resolve_one(1'b1, 5'd20);
    checks++;
    if (upd_valid !== 1'b0 || hit_cnt !== 8'd0) begin
      failures++;
      $display("FAIL flush_push_discarded upd_valid=%b hit=%0d required 0 0", upd_valid, hit_cnt);
    end
    $display("test_flush done");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 258; i++) begin
      push_one(5'd2, 1'b0, 5'd0);
      resolve_one(1'b0, 5'd0);
    end
    checks++;
    if (hit_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL hit_saturate hit=%0d required 255", hit_cnt);
    end
    $display("test_saturate done hit_cnt=%0d", hit_cnt);
  endtask

  initial begin
    test_reset();
    test_correct_stream();
    test_mispredict();
    test_redirect();
    test_full();
    test_flush();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
